// File: rtl/fpu_addsub_param.sv
// Multi-cycle add/subtract unit for the custom sign/exponent/fraction float format.
// Aligns with guard/round/sticky, normalises one bit per cycle, rounds to nearest even.
module fpu_addsub_param #(
   parameter int EXP_W = 6,
   parameter int MAN_W = 25,
   parameter int BIAS  = 2**(EXP_W-1)-1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start_in,
   input  logic                 op_sel_in,
   input  logic [EXP_W+MAN_W:0] op_A_in,
   input  logic [EXP_W+MAN_W:0] op_B_in,
   output logic                 ready_out,
   output logic                 done_out,
   output logic [EXP_W+MAN_W:0] data_out,
   output logic [3:0]           status_out
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int SW = MAN_W + 1;
   localparam int FW = SW + 3;
   localparam int XW = EXP_W + 2;
   // The all-ones biased exponent (2*BIAS+1 with a symmetric bias) is the overflow code.
   localparam logic signed [XW-1:0] EXP_OVF  = XW'(2*BIAS + 1);
   localparam logic signed [XW-1:0] EXP_ZERO = '0;
   localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);

   typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [W-1:0]         op_a_q, op_a_d, op_b_q, op_b_d;
   logic                 sub_q, sub_d;
   logic [FW-1:0]        big_q, big_d, sml_q, sml_d;
   logic                 sign_big_q, sign_big_d, sign_sml_q, sign_sml_d;
   logic                 sign_q, sign_d;
   logic signed [XW-1:0] exp_q, exp_d;
   logic [FW:0]          man_q, man_d;
   logic [W-1:0]         data_q, data_d;
   logic [3:0]           status_q, status_d;
   logic                 done_q, done_d;

   function automatic logic [FW-1:0] align_grs(input logic [SW-1:0] sig,
                                                input logic [EXP_W-1:0] sh);
      logic [FW-1:0] ext, shifted, lost_mask;
      ext       = {sig, 3'b000};
      shifted   = ext >> sh;
      lost_mask = ~({FW{1'b1}} << sh);
      return {shifted[FW-1:1], shifted[0] | (|(ext & lost_mask))};
   endfunction

   // Returns {status, word}; man carries hidden bit at FW-1 and G/R/S in the low bits.
   function automatic logic [W+3:0] round_pack(input logic sign,
                                               input logic signed [XW-1:0] exp_in,
                                               input logic [FW:0] man);
      logic [SW-1:0]        sig;
      logic [SW:0]          rsum;
      logic                 inexact, up;
      logic signed [XW-1:0] e;
      logic [W-1:0]         word;
      logic [3:0]           flags;
      sig     = man[FW-1:3];
      inexact = man[2] | man[1] | man[0];
      up      = man[2] & (man[1] | man[0] | sig[0]);
      rsum    = {1'b0, sig} + {{SW{1'b0}}, up};
      e       = exp_in;
      if (rsum[SW]) begin
         rsum = rsum >> 1;
         e    = e + EXP_ONE;
      end
      if (man == '0) begin
         word  = {sign, {(W-1){1'b0}}};
         flags = 4'b0001;
      end else if (e >= EXP_OVF) begin
         word  = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flags = 4'b1010;
      end else if (e <= EXP_ZERO) begin
         word  = {sign, {(W-1){1'b0}}};
         flags = 4'b1101;
      end else begin
         word  = {sign, e[EXP_W-1:0], rsum[MAN_W-1:0]};
         flags = {inexact, 3'b000};
      end
      return {flags, word};
   endfunction

   logic [EXP_W-1:0] exp_a, exp_b, exp_diff;
   logic [SW-1:0]    sig_a, sig_b;
   logic             a_ge_b, sgn_a, sgn_b;
   logic [FW:0]      sum_add, sum_sub;
   logic [W+3:0]     rounded;

   assign exp_a    = op_a_q[W-2:MAN_W];
   assign exp_b    = op_b_q[W-2:MAN_W];
   assign sig_a    = (exp_a == '0) ? '0 : {1'b1, op_a_q[MAN_W-1:0]};
   assign sig_b    = (exp_b == '0) ? '0 : {1'b1, op_b_q[MAN_W-1:0]};
   assign sgn_a    = op_a_q[W-1];
   assign sgn_b    = op_b_q[W-1] ^ sub_q;
   assign a_ge_b   = op_a_q[W-2:0] >= op_b_q[W-2:0];
   assign exp_diff = a_ge_b ? (exp_a - exp_b) : (exp_b - exp_a);
   assign sum_add  = {1'b0, big_q} + {1'b0, sml_q};
   assign sum_sub  = {1'b0, big_q - sml_q};
   assign rounded  = round_pack(sign_q, exp_q, man_q);

   always_comb begin
      state_d    = state_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      sub_d      = sub_q;
      big_d      = big_q;
      sml_d      = sml_q;
      sign_big_d = sign_big_q;
      sign_sml_d = sign_sml_q;
      sign_d     = sign_q;
      exp_d      = exp_q;
      man_d      = man_q;
      data_d     = data_q;
      status_d   = status_q;
      done_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_in) begin
               op_a_d  = op_A_in;
               op_b_d  = op_B_in;
               sub_d   = op_sel_in;
               state_d = S_ALIGN;
            end
         end
         S_ALIGN: begin
            big_d      = a_ge_b ? {sig_a, 3'b000} : {sig_b, 3'b000};
            sml_d      = align_grs(a_ge_b ? sig_b : sig_a, exp_diff);
            sign_big_d = a_ge_b ? sgn_a : sgn_b;
            sign_sml_d = a_ge_b ? sgn_b : sgn_a;
            exp_d      = signed'({2'b00, (a_ge_b ? exp_a : exp_b)});
            state_d    = S_ADD;
         end
         S_ADD: begin
            man_d   = (sign_big_q == sign_sml_q) ? sum_add : sum_sub;
            // Only a sum of two negative zeros keeps the minus sign.
            sign_d  = (man_d == '0) ? (sign_big_q & sign_sml_q) : sign_big_q;
            state_d = S_NORM;
         end
         S_NORM: begin
            if (man_q[FW]) begin
               man_d   = {1'b0, man_q[FW:2], man_q[1] | man_q[0]};
               exp_d   = exp_q + EXP_ONE;
               state_d = S_ROUND;
            end else if ((man_q != '0) && !man_q[FW-1]) begin
               man_d = man_q << 1;
               exp_d = exp_q - EXP_ONE;
            end else begin
               state_d = S_ROUND;
            end
         end
         S_ROUND: begin
            {status_d, data_d} = rounded;
            done_d             = 1'b1;
            state_d            = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         op_a_q     <= '0;
         op_b_q     <= '0;
         sub_q      <= 1'b0;
         big_q      <= '0;
         sml_q      <= '0;
         sign_big_q <= 1'b0;
         sign_sml_q <= 1'b0;
         sign_q     <= 1'b0;
         exp_q      <= '0;
         man_q      <= '0;
         data_q     <= '0;
         status_q   <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         sub_q      <= sub_d;
         big_q      <= big_d;
         sml_q      <= sml_d;
         sign_big_q <= sign_big_d;
         sign_sml_q <= sign_sml_d;
         sign_q     <= sign_d;
         exp_q      <= exp_d;
         man_q      <= man_d;
         data_q     <= data_d;
         status_q   <= status_d;
         done_q     <= done_d;
      end
   end

   assign ready_out  = (state_q == S_IDLE);
   assign done_out   = done_q;
   assign data_out   = data_q;
   assign status_out = status_q;

endmodule
